mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//   MEM stage load/store engine. Sits directly upstream of the write-back stage.
//   Issues one data-memory transaction per load/store over a req/ack handshake.
//   Formats load data (byte/half/word, sign or zero extend) into readData for write-back.
//   Holds the pipeline via stall until the transaction completes.
// PARAMETERS
//   SIZE    32   data width; fixed at 32 (4 byte lanes)
//   ADDR_W  32   address width
// PORTS
//   clk          in   1       rising-edge clock
//   rst_n        in   1       asynchronous reset, active-low
//   MemRead      in   1       load request for current MEM instruction
//   MemWrite     in   1       store request; wins if MemRead also set
//   memSize      in   2       00 byte, 01 half, 10 word, 11 treated as word
//   memUnsigned  in   1       1 = zero-extend loads, 0 = sign-extend
//   address      in   ADDR_W  byte address (ALU result)
//   storeData    in   SIZE    store source register value
//   dmem_req     out  1       transaction request (registered)
//   dmem_we      out  1       1 = write
//   dmem_addr    out  ADDR_W  word address {address[ADDR_W-1:2],2'b00}
//   dmem_be      out  4       byte enables
//   dmem_wdata   out  SIZE    store data, lane-replicated
//   dmem_ack     in   1       memory completion; rdata valid same cycle for reads
//   dmem_rdata   in   SIZE    read word
//   readData     out  SIZE    formatted load result to write-back (registered)
//   stall        out  1       hold IF/ID/EX/MEM registers (combinational)
//   misaligned   out  1       alignment fault flag (combinational, IDLE only)
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE; dmem_req, dmem_we=0; dmem_addr, dmem_be, dmem_wdata=0; readData=0.
//   acc = MemRead|MemWrite. mis = (half & address[0]) | (word & |address[1:0]).
//   FSM states: IDLE, REQ, DONE.
//   IDLE:
//     - acc & !mis: latch addr/we/be/wdata; dmem_req<=1; go REQ.
//     - acc & mis: misaligned=1; no request; no stall; readData unchanged; stay IDLE.
//   REQ:
//     - dmem_req, dmem_addr, dmem_we, dmem_be and dmem_wdata held stable until dmem_ack.
//     - On ack: dmem_req<=0; if read, readData<=formatted rdata; go DONE.
//     - A write does not change readData.
//   DONE: stall=0 for exactly one cycle so the pipeline advances; go IDLE unconditionally.
//     - This prevents re-issuing the same instruction.
//   stall = (IDLE & acc & !mis) | REQ. Per access: 1 + N stall cycles, N = cycles in REQ until ack (>=1).
//   Byte enables:
//     - byte: 4'b0001<<address[1:0].
//     - half: address[1] ? 4'b1100 : 4'b0011.
//     - word: 4'b1111.
//   wdata: byte {4{sd[7:0]}}, half {2{sd[15:0]}}, word sd.
//   Load format: select lane by address[1:0] (byte) or address[1] (half); extend to 32 per memUnsigned.
//   Inputs are sampled only in IDLE; changes during REQ/DONE are ignored.
//   dmem_ack outside REQ is ignored.
//   rst_n low mid-transaction: abort immediately, dmem_req drops asynchronously, return to IDLE.
// TESTING
//   1. LW addr=0x100, ack after 3 cycles, rdata=0xDEADBEEF.
//      -> be=1111, addr=0x100, stall high 4 cycles, readData=0xDEADBEEF in DONE.
//   2. LB addr=0x103, signed, rdata=0x80112233.
//      -> be=1000, readData=0xFFFFFF80; with memUnsigned=1 -> 0x00000080.
//   3. SH addr=0x102, storeData=0x0000ABCD, ack after 1 cycle.
//      -> we=1, be=1100, wdata=0xABCDABCD, stall 2 cycles, readData unchanged.
//   4. LW addr=0x101. -> misaligned=1, dmem_req never rises, stall=0.
//      LH addr=0x101 -> same.
//   5. rst_n pulsed low in REQ.
//      -> dmem_req=0 immediately, state IDLE, readData=0; spurious later ack ignored.
//   6. Back-to-back LW then SW, ack held high.
//      -> two distinct requests separated by the DONE cycle; no duplicate issue.

Source files
------------

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM stage load/store engine with req/ack data-memory handshake
module mem_access_unit #(
   parameter int SIZE   = 32,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic [1:0]        memSize,
   input  logic              memUnsigned,
   input  logic [ADDR_W-1:0] address,
   input  logic [SIZE-1:0]   storeData,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [3:0]        dmem_be,
   output logic [SIZE-1:0]   dmem_wdata,
   input  logic              dmem_ack,
   input  logic [SIZE-1:0]   dmem_rdata,
   output logic [SIZE-1:0]   readData,
   output logic              stall,
   output logic              misaligned
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state, state_nxt;
   logic            acc, mis, issue, is_half, is_word;
   logic [3:0]      be_c;
   logic [SIZE-1:0] wdata_c, load_fmt;
   logic [1:0]      lane_q, size_q;
   logic            uns_q;
   logic [7:0]      lb;
   logic [15:0]     lh;

   assign acc     = MemRead | MemWrite;
   assign is_half = (memSize == 2'b01);
   assign is_word = memSize[1];
   assign mis     = (is_half & address[0]) | (is_word & (|address[1:0]));

   always_comb begin
      be_c    = 4'b1111;
      wdata_c = storeData;
      case (memSize)
         2'b00: begin
            be_c    = 4'b0001 << address[1:0];
            wdata_c = {4{storeData[7:0]}};
         end
         2'b01: begin
            be_c    = address[1] ? 4'b1100 : 4'b0011;
            wdata_c = {2{storeData[15:0]}};
         end
         default: ;
      endcase
   end

   // Lane selection uses the size/offset captured at issue, not the live inputs.
   always_comb begin
      lb       = dmem_rdata[{lane_q, 3'b000} +: 8];
      lh       = lane_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      load_fmt = dmem_rdata;
      case (size_q)
         2'b00:   load_fmt = {{(SIZE-8){~uns_q & lb[7]}}, lb};
         2'b01:   load_fmt = {{(SIZE-16){~uns_q & lh[15]}}, lh};
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (acc && !mis) state_nxt = REQ;
         REQ:     if (dmem_ack)    state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      issue      = (state == IDLE) & acc & ~mis;
      stall      = issue | (state == REQ);
      misaligned = (state == IDLE) & acc & mis;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_be    <= '0;
         dmem_wdata <= '0;
         readData   <= '0;
         lane_q     <= '0;
         size_q     <= '0;
         uns_q      <= 1'b0;
      end else if (issue) begin
         dmem_req   <= 1'b1;
         dmem_we    <= MemWrite;
         dmem_addr  <= {address[ADDR_W-1:2], 2'b00};
         dmem_be    <= be_c;
         dmem_wdata <= wdata_c;
         lane_q     <= address[1:0];
         size_q     <= memSize;
         uns_q      <= memUnsigned;
      end else if (state == REQ && dmem_ack) begin
         dmem_req <= 1'b0;
         if (!dmem_we) readData <= load_fmt;
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit with a behavioural memory model
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_read, mem_write, mem_unsigned;
   logic [1:0]  mem_size;
   logic [31:0] address, store_data;
   logic        dmem_req, dmem_we, dmem_ack;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, read_data;
   logic [3:0]  dmem_be;
   logic        stall, misaligned;

   int n_vec = 0;
   int n_err = 0;

   logic [68:0] txn_q[$];
   int          lat_q[$];
   logic [31:0] rd_q[$];
   logic [31:0] mem[logic [31:0]];
   logic [31:0] rd_model = 32'h0;
   logic        force_ack = 1'b0;

   always #5 clk = ~clk;

   mem_access_unit #(.SIZE(32), .ADDR_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .MemRead(mem_read), .MemWrite(mem_write), .memSize(mem_size), .memUnsigned(mem_unsigned),
      .address(address), .storeData(store_data),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
      .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .readData(read_data), .stall(stall), .misaligned(misaligned)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] get_word(input logic [31:0] wa);
      if (!mem.exists(wa)) mem[wa] = (wa * 32'h9E3779B1) ^ 32'h5A5A1234;
      return mem[wa];
   endfunction

   // Issue one instruction (called just after a rising edge), hold it until the pipeline advances.
   task automatic do_instr(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] sd, input int lat);
      int          nb, exp_stall, n;
      logic        acc, mis;
      logic [31:0] rep, v, mask;
      logic [3:0]  be;
      nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      acc = rd | wr;
      mis = (nb == 2 && a % 2 != 0) || (nb == 4 && a % 4 != 0);
      mem_read = rd; mem_write = wr; mem_size = sz; mem_unsigned = uns;
      address = a; store_data = sd;
      exp_stall = 0;
      if (acc && !mis) begin
         for (int l = 0; l < 4; l++) rep[8*l +: 8] = sd[8*(l % nb) +: 8];
         be = 4'(((1 << nb) - 1) << (a % 4));
         txn_q.push_back({wr, be, a & ~32'h3, rep});
         lat_q.push_back(lat);
         if (!wr) begin
            v    = get_word(a & ~32'h3) >> (8 * (a % 4));
            mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 1);
            v    = v & mask;
            if (!uns && nb < 4 && v[8*nb-1]) v = v | ~mask;
            rd_model = v;
         end
         rd_q.push_back(rd_model);
         exp_stall = 1 + lat;
      end
      n = 0;
      @(negedge clk);
      chk("misaligned", misaligned, acc && mis);
      if (acc && mis) chk("no_req_when_misaligned", dmem_req, 1'b0);
      while (stall) begin
         n++;
         if (n > 60) begin
            chk("stall_timeout", 1'b1, 1'b0);
            break;
         end
         @(negedge clk);
      end
      chk("stall_cycles", n, exp_stall);
      if (!(acc && !mis)) chk("read_data_held", read_data, rd_model);
      @(posedge clk);
      #1;
      mem_read = 1'b0; mem_write = 1'b0;
   endtask

   // Memory responder and scoreboard monitor.
   initial begin
      logic [68:0] cur;
      logic [31:0] w;
      int          cnt, cur_lat;
      logic        active;
      dmem_ack = 1'b0; dmem_rdata = 32'h0; active = 1'b0; cnt = 0; cur_lat = 1; cur = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            active = 1'b0;
            txn_q.delete(); lat_q.delete(); rd_q.delete();
            dmem_ack = 1'b0;
            continue;
         end
         if (dmem_req) begin
            if (!active) begin
               active = 1'b1;
               cnt    = 0;
               if (txn_q.size() == 0) begin
                  chk("unexpected_request", dmem_req, 1'b0);
                  cur = {dmem_we, dmem_be, dmem_addr, dmem_wdata};
                  cur_lat = 1;
               end else begin
                  cur = txn_q.pop_front();
                  cur_lat = lat_q.pop_front();
               end
            end
            chk("txn_we_be_addr_wdata", {dmem_we, dmem_be, dmem_addr, dmem_wdata}, cur);
            cnt++;
            if (cnt >= cur_lat || force_ack) begin
               dmem_ack = 1'b1;
               if (dmem_we) begin
                  w = get_word(dmem_addr);
                  for (int l = 0; l < 4; l++)
                     if (dmem_be[l]) w[8*l +: 8] = dmem_wdata[8*l +: 8];
                  mem[dmem_addr] = w;
                  dmem_rdata = $urandom;
               end else begin
                  dmem_rdata = get_word(dmem_addr);
               end
            end else begin
               dmem_ack = 1'b0;
               dmem_rdata = $urandom;
            end
         end else begin
            if (active) begin
               active = 1'b0;
               if (rd_q.size() != 0) chk("read_data_done", read_data, rd_q.pop_front());
            end
            dmem_ack   = force_ack || ($urandom_range(0, 3) == 0);
            dmem_rdata = $urandom;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int op;
      rst_n = 1'b0;
      mem_read = 0; mem_write = 0; mem_size = 0; mem_unsigned = 0; address = 0; store_data = 0;
      repeat (2) @(negedge clk);
      chk("reset_outputs", {dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, read_data, stall},
          '0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      mem[32'h100] = 32'hDEADBEEF;
      do_instr(1, 0, 2'b10, 0, 32'h100, 32'h0, 3);
      mem[32'h100] = 32'h80112233;
      do_instr(1, 0, 2'b00, 0, 32'h103, 32'h0, 2);
      do_instr(1, 0, 2'b00, 1, 32'h103, 32'h0, 1);
      do_instr(0, 1, 2'b01, 0, 32'h102, 32'h0000ABCD, 1);
      do_instr(1, 0, 2'b10, 0, 32'h101, 32'h0, 1);
      do_instr(1, 0, 2'b01, 0, 32'h101, 32'h0, 1);
      do_instr(1, 0, 2'b00, 0, 32'h102, 32'h0, 4);

      force_ack = 1'b1;
      do_instr(1, 0, 2'b10, 0, 32'h100, 32'h0, 1);
      do_instr(0, 1, 2'b10, 0, 32'h104, 32'h1234_5678, 1);
      force_ack = 1'b0;

      // Reset while a load is outstanding, then spurious acks must leave everything idle.
      mem_read = 1; mem_write = 0; mem_size = 2'b10; mem_unsigned = 0; address = 32'h300;
      txn_q.push_back({1'b0, 4'b1111, 32'h300, store_data});
      lat_q.push_back(8);
      rd_q.push_back(get_word(32'h300));
      repeat (3) @(negedge clk);
      #2;
      mem_read = 0;
      rst_n = 1'b0;
      #1;
      chk("reset_mid_req", {dmem_req, read_data, stall}, '0);
      @(negedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1;
      rd_model = 32'h0;
      force_ack = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("spurious_ack_ignored", {dmem_req, read_data, stall}, '0);
      end
      force_ack = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 300; i++) begin
         op = $urandom_range(0, 5);
         do_instr(op inside {1, 2, 5}, op inside {3, 4, 5}, 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 32'h200 + 32'($urandom_range(0, 31)), $urandom,
                  $urandom_range(1, 5));
      end

      repeat (4) @(negedge clk);
      chk("scoreboard_drained", txn_q.size() + rd_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
